// File: rtl/fft_buf_ring_pkg.sv
// rtl/fft_buf_ring_pkg.sv - shared buffer/engine state types and ring size limits
package fft_buf_ring_pkg;

    // Legal ring sizes and the smallest frame the address logic supports
    localparam int NUM_BUF_MIN    = 2;
    localparam int NUM_BUF_MAX    = 8;
    localparam int FFT_LENGTH_MIN = 4;

    // Lifecycle of one frame buffer: filled by the stream, transformed, drained by DMA
    typedef enum logic [2:0] {
        FREE   = 3'd0,
        FILL   = 3'd1,
        FULL   = 3'd2,
        BUSY   = 3'd3,
        RESULT = 3'd4
    } buf_state_t;

    // FFT engine ownership: idle, or running on buffer[fft_ptr]
    typedef enum logic {
        ENG_IDLE = 1'b0,
        ENG_RUN  = 1'b1
    } eng_state_t;

endpackage

// File: rtl/fft_buf_ring_fill_cnt.sv
// rtl/fft_buf_ring_fill_cnt.sv - per-frame sample counter with bit-reversed write address
module fft_buf_ring_fill_cnt
    import fft_buf_ring_pkg::*;
#(
    parameter  int FFT_LENGTH = 1024,
    localparam int FFT_N      = $clog2(FFT_LENGTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    output logic [FFT_N-1:0] addr,
    output logic             cnt_zero,
    output logic             frame_done
);

    logic [FFT_N-1:0] sample_cnt;

    assign cnt_zero   = (sample_cnt == '0);
    assign frame_done = wr_en && (sample_cnt == FFT_N'(FFT_LENGTH - 1));

    // Count accepted samples; the last sample of a frame wraps back to zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_cnt <= '0;
        end else if (wr_en) begin
            if (frame_done) begin
                sample_cnt <= '0;
            end else begin
                sample_cnt <= sample_cnt + FFT_N'(1);
            end
        end
    end

    // Mirror the counter bits so samples land in bit-reversed order for the in-place FFT
    always_comb begin
        addr = '0;
        for (int i = 0; i < FFT_N; i++) begin
            addr[i] = sample_cnt[FFT_N-1-i];
        end
    end

endmodule

// File: rtl/fft_buf_ring_ctrl.sv
// rtl/fft_buf_ring_ctrl.sv - frame-buffer ring controller (stream fill -> FFT -> DMA); optional FFT_BUF_RING_OVERWRITE_EN
module fft_buf_ring_ctrl
    import fft_buf_ring_pkg::*;
#(
    parameter  int NUM_BUF    = 3,
    parameter  int FFT_LENGTH = 1024,
    localparam int FFT_N      = $clog2(FFT_LENGTH),
    localparam int BUF_IDX_W  = (NUM_BUF > 2) ? $clog2(NUM_BUF) : 1,
    localparam int CNT_W      = $clog2(NUM_BUF + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sact_istream,
    output logic                 istream_wen,
    output logic [FFT_N-1:0]     istream_addr,
    output logic [BUF_IDX_W-1:0] istream_buf,
    output logic                 fft_start,
    output logic [BUF_IDX_W-1:0] fft_buf,
    input  logic                 fft_done,
    output logic                 dma_ready,
    output logic [BUF_IDX_W-1:0] dma_buf,
    input  logic                 dma_release,
    input  logic                 clr_overrun,
    output logic                 overrun,
    output logic [CNT_W-1:0]     free_count
);

    buf_state_t           buf_state     [NUM_BUF];
    buf_state_t           buf_state_nxt [NUM_BUF];
    eng_state_t           eng_state;
    logic [BUF_IDX_W-1:0] wr_ptr;
    logic [BUF_IDX_W-1:0] fft_ptr;
    logic [BUF_IDX_W-1:0] dma_ptr;
    logic [CNT_W-1:0]     free_nxt;

    logic                 wr_open;
    logic                 reclaim;
    logic                 cnt_zero;
    logic                 frame_done;
    logic                 fft_finish;
    logic                 dma_free;
    logic                 overrun_evt;

    function automatic logic [BUF_IDX_W-1:0] ptr_inc(input logic [BUF_IDX_W-1:0] p);
        if (p == BUF_IDX_W'(NUM_BUF - 1)) begin
            return '0;
        end
        return p + BUF_IDX_W'(1);
    endfunction

    fft_buf_ring_fill_cnt #(
        .FFT_LENGTH (FFT_LENGTH)
    ) u_fill_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (istream_wen),
        .addr       (istream_addr),
        .cnt_zero   (cnt_zero),
        .frame_done (frame_done)
    );

    // The write buffer accepts samples only while it is free or part-way through a frame
    assign wr_open = (buf_state[wr_ptr] == FREE) || (buf_state[wr_ptr] == FILL);

`ifdef FFT_BUF_RING_OVERWRITE_EN
    // A full ring whose oldest entry is an undrained result gives that buffer to the new frame
    assign reclaim = rst_n && sact_istream && cnt_zero
                     && (wr_ptr == dma_ptr) && (buf_state[wr_ptr] == RESULT);
`else
    logic unused_cnt_zero;
    assign unused_cnt_zero = cnt_zero;
    assign reclaim         = 1'b0;
`endif

    assign istream_wen = rst_n && sact_istream && (wr_open || reclaim);
    assign istream_buf = wr_ptr;
    assign overrun_evt = (rst_n && sact_istream && !istream_wen) || reclaim;

    assign fft_start  = (eng_state == ENG_IDLE) && (buf_state[fft_ptr] == FULL);
    assign fft_buf    = fft_ptr;
    assign fft_finish = (eng_state == ENG_RUN) && fft_done;

    assign dma_ready = (buf_state[dma_ptr] == RESULT);
    assign dma_buf   = dma_ptr;
    assign dma_free  = dma_release && dma_ready;

    // Apply this cycle's fill, engine and DMA transitions; each targets a different buffer
    always_comb begin
        buf_state_nxt = buf_state;
        if (dma_free) begin
            buf_state_nxt[dma_ptr] = FREE;
        end
        if (fft_start) begin
            buf_state_nxt[fft_ptr] = BUSY;
        end
        if (fft_finish) begin
            buf_state_nxt[fft_ptr] = RESULT;
        end
        if (istream_wen) begin
            buf_state_nxt[wr_ptr] = frame_done ? FULL : FILL;
        end
        free_nxt = '0;
        for (int i = 0; i < NUM_BUF; i++) begin
            if (buf_state_nxt[i] == FREE) begin
                free_nxt = free_nxt + CNT_W'(1);
            end
        end
    end

    // Register buffer states together with the matching free-buffer count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BUF; i++) begin
                buf_state[i] <= FREE;
            end
            free_count <= CNT_W'(NUM_BUF);
        end else begin
            buf_state  <= buf_state_nxt;
            free_count <= free_nxt;
        end
    end

    // Advance each ring pointer as its stage hands a buffer on, keeping strict arrival order
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            fft_ptr <= '0;
            dma_ptr <= '0;
        end else begin
            if (frame_done) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (fft_finish) begin
                fft_ptr <= ptr_inc(fft_ptr);
            end
            if (dma_free || reclaim) begin
                dma_ptr <= ptr_inc(dma_ptr);
            end
        end
    end

    // Engine ownership: a start claims it, a completion pulse hands it back
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            eng_state <= ENG_IDLE;
        end else begin
            case (eng_state)
                ENG_IDLE: if (fft_start) eng_state <= ENG_RUN;
                ENG_RUN:  if (fft_done)  eng_state <= ENG_IDLE;
                default:  eng_state <= ENG_IDLE;
            endcase
        end
    end

    // Sticky drop flag; a new drop in the clearing cycle keeps it set
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (overrun_evt) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_buf_ring_ctrl.sv
// tb/tb_fft_buf_ring_ctrl.sv - directed and random checks of fft_buf_ring_ctrl against a frame-count model
module tb_fft_buf_ring_ctrl;

    localparam int NB = 3;
    localparam int FL = 8;
    localparam int FN = 3;
    localparam int BW = 2;
    localparam int CW = 2;

    logic          clk          = 1'b0;
    logic          rst_n        = 1'b0;
    logic          sact_istream = 1'b0;
    logic          fft_done     = 1'b0;
    logic          dma_release  = 1'b0;
    logic          clr_overrun  = 1'b0;
    logic          istream_wen;
    logic [FN-1:0] istream_addr;
    logic [BW-1:0] istream_buf;
    logic          fft_start;
    logic [BW-1:0] fft_buf;
    logic          dma_ready;
    logic [BW-1:0] dma_buf;
    logic          overrun;
    logic [CW-1:0] free_count;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: frames completed by fill (w), started (s), finished (d), released (r)
    int m_w, m_s, m_d, m_r, m_cnt;
    bit m_ovr;

    logic          obs_wen;
    logic [FN-1:0] obs_addr;
    logic [BW-1:0] obs_buf;
    logic          obs_start;

    int addr_tbl [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    fft_buf_ring_ctrl #(
        .NUM_BUF    (NB),
        .FFT_LENGTH (FL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sact_istream (sact_istream),
        .istream_wen  (istream_wen),
        .istream_addr (istream_addr),
        .istream_buf  (istream_buf),
        .fft_start    (fft_start),
        .fft_buf      (fft_buf),
        .fft_done     (fft_done),
        .dma_ready    (dma_ready),
        .dma_buf      (dma_buf),
        .dma_release  (dma_release),
        .clr_overrun  (clr_overrun),
        .overrun      (overrun),
        .free_count   (free_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int bitrev(input int x);
        int v = x;
        int r = 0;
        for (int k = 0; k < FN; k++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_w = 0; m_s = 0; m_d = 0; m_r = 0; m_cnt = 0; m_ovr = 0;
    endtask

    // One clock cycle: drive, check outputs at the falling edge against the model, advance the model
    task automatic cycle(input bit s, input bit dn, input bit rl, input bit cl);
        bit writable, reclaim, wen, start, fin, rdy, freed;
        sact_istream = s; fft_done = dn; dma_release = rl; clr_overrun = cl;
        @(negedge clk);
        writable = (m_w - m_r) < NB;
        reclaim  = 1'b0;
`ifdef FFT_BUF_RING_OVERWRITE_EN
        reclaim  = s && (m_cnt == 0) && !writable && (m_d > m_r);
`endif
        wen   = s && (writable || reclaim);
        start = (m_s == m_d) && (m_s < m_w);
        fin   = dn && (m_s > m_d);
        rdy   = m_d > m_r;
        freed = rl && rdy;
        obs_wen = istream_wen; obs_addr = istream_addr; obs_buf = istream_buf; obs_start = fft_start;
        chk("istream_wen", istream_wen, wen);
        if (wen) chk("istream_addr", istream_addr, bitrev(m_cnt));
        chk("istream_buf", istream_buf, m_w % NB);
        chk("fft_start", fft_start, start);
        chk("fft_buf", fft_buf, m_d % NB);
        chk("dma_ready", dma_ready, rdy);
        chk("dma_buf", dma_buf, m_r % NB);
        chk("free_count", free_count, NB - (m_w - m_r) - ((m_cnt > 0) ? 1 : 0));
        chk("overrun", overrun, m_ovr);
        if (start) m_s++;
        if (fin) m_d++;
        if (freed || reclaim) m_r++;
        if (wen) begin
            if (m_cnt == FL - 1) begin
                m_w++;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        if ((s && !wen) || reclaim) m_ovr = 1'b1;
        else if (cl) m_ovr = 1'b0;
        @(posedge clk);
        #1;
        sact_istream = 0; fft_done = 0; dma_release = 0; clr_overrun = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; sact_istream = 1; fft_done = 0; dma_release = 0; clr_overrun = 0;
        @(posedge clk);
        #1;
        chk("rst_wen", istream_wen, 0);
        chk("rst_addr", istream_addr, 0);
        chk("rst_buf", istream_buf, 0);
        chk("rst_fft_start", fft_start, 0);
        chk("rst_dma_ready", dma_ready, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_free_count", free_count, NB);
        @(posedge clk);
        #1;
        rst_n = 1; sact_istream = 0;
        model_reset();
    endtask

    initial begin
        model_reset();
        do_reset();
        cycle(0, 0, 0, 0);

        // First frame: bit-reversed addresses, then FFT start on buffer 0
        for (int i = 0; i < FL; i++) begin
            cycle(1, 0, 0, 0);
            chk("req044_addr", obs_addr, addr_tbl[i]);
            chk("req044_buf", obs_buf, 0);
        end
        cycle(0, 0, 0, 0);
        chk("req044_fft_start", obs_start, 1);
        cycle(0, 0, 0, 0);

        // Completion then DMA drain
        cycle(0, 1, 0, 0);
        chk("req045_dma_ready", dma_ready, 1);
        chk("req045_dma_buf", dma_buf, 0);
        cycle(0, 0, 1, 0);
        chk("req045_dma_ready_off", dma_ready, 0);
        chk("req045_free", free_count, NB);

        // Four frames without completion: the fourth is dropped
        for (int i = 0; i < 4 * FL; i++) cycle(1, 0, 0, 0);
        chk("req046_free", free_count, 0);
        chk("req046_overrun", overrun, 1);
        cycle(0, 0, 0, 1);
        chk("clr_overrun", overrun, 0);
        cycle(1, 0, 0, 1);
        chk("set_wins", overrun, 1);

        // Finish one frame, then finish the next while releasing the first
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 1, 1, 0);
        chk("req047_same_cycle_wen", obs_wen, 0);
        chk("req047_dma_ready", dma_ready, 1);
        cycle(1, 0, 0, 0);
        chk("req047_next_wen", obs_wen, 1);

        // Reset during a fill discards the partial frame
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
        do_reset();
        cycle(1, 0, 0, 0);
        chk("req049_addr", obs_addr, 0);
        chk("req049_buf", obs_buf, 0);
        chk("req049_overrun", overrun, 0);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 2,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
        end

`ifdef FFT_BUF_RING_OVERWRITE_EN
        // All buffers hold results: a new strobe reclaims the oldest
        do_reset();
        for (int i = 0; i < NB * FL; i++) cycle(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);
        chk("req048_wen", obs_wen, 1);
        chk("req048_dma_buf", dma_buf, 1);
        chk("req048_overrun", overrun, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
